// File: rtl/shift_pq_pkg.sv
// Shared types and helpers for the shift/priority queue.
// Used by shift_pq_cell and shift_pqueue.
package shift_pq_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef logic signed [MaxWidth-1:0] cmp_t;

    typedef enum logic [1:0] {
        HOLD,
        LOAD_NEW,
        TAKE_LOWER,
        TAKE_UPPER
    } slot_op_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Signed a <= b; callers sign-extend their operands into cmp_t.
    function automatic logic le(input cmp_t a, input cmp_t b);
        return a <= b;
    endfunction

endpackage

// File: rtl/shift_pq_cell.sv
// One queue slot: a data register that loads the pushed element, a neighbour,
// or holds, as chosen by the slot-op decode in the parent.
module shift_pq_cell
    import shift_pq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  slot_op_e         op,
    input  logic [WIDTH-1:0] lower_data,
    input  logic [WIDTH-1:0] upper_data,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        unique case (op)
            HOLD:       data_d = data_q;
            LOAD_NEW:   data_d = push_data;
            TAKE_LOWER: data_d = lower_data;
            TAKE_UPPER: data_d = upper_data;
            default:    data_d = data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/shift_pqueue.sv
// DEPTH-slot element queue with push/pop handshakes and eviction on overflow.
// Define SHIFT_PQ_SORT_EN for an ascending systolic priority queue; otherwise a shift-in FIFO.
module shift_pqueue
    import shift_pq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 6
) (
    input  logic                         system1000,
    input  logic                         system1000_rstn,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [WIDTH-1:0]             push_data_i,
    output logic                         pop_valid_o,
    input  logic                         pop_ready_i,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic                         evict_valid_o,
    output logic [WIDTH-1:0]             evict_data_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o,
    output logic [DEPTH*WIDTH-1:0]       vec_o
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] slot_data [DEPTH];
    slot_op_e         slot_op   [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [CW-1:0]    count_q, count_d;
    logic             ready_q;
    logic             evict_valid_q, evict_valid_d;
    logic [WIDTH-1:0] evict_data_q, evict_data_d;

    logic push_fire, pop_fire, full;

    assign push_fire = push_valid_i & ready_q;
    assign pop_fire  = pop_ready_i & (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));

    // Valid slots are always the contiguous prefix [0, count).
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (CW'(i) < count_q);
        end
    end

`ifdef SHIFT_PQ_SORT_EN
    logic [CW-1:0] ins_pos;
    logic [CW-1:0] rem_pos;

    // Number of valid slots <= push data; ties insert after existing equals.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && le(cmp_t'($signed(slot_data[i])), cmp_t'($signed(push_data_i)))) begin
                ins_pos = ins_pos + CW'(1);
            end
        end
    end

    always_comb begin
        count_d       = count_q;
        evict_valid_d = 1'b0;
        evict_data_d  = evict_data_q;
        rem_pos       = (ins_pos == '0) ? '0 : ins_pos - CW'(1);
        for (int i = 0; i < DEPTH; i++) begin
            slot_op[i] = HOLD;
        end
        if (push_fire && pop_fire) begin
            // Head leaves; the slots below the insertion point slide down to close the gap.
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < rem_pos)       slot_op[i] = TAKE_UPPER;
                else if (CW'(i) == rem_pos) slot_op[i] = LOAD_NEW;
                else                        slot_op[i] = HOLD;
            end
        end else if (push_fire) begin
            if (full && ins_pos == CW'(DEPTH)) begin
                evict_valid_d = 1'b1;
                evict_data_d  = push_data_i;
            end else begin
                if (full) begin
                    evict_valid_d = 1'b1;
                    evict_data_d  = slot_data[DEPTH-1];
                end else begin
                    count_d = count_q + CW'(1);
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) < ins_pos)       slot_op[i] = HOLD;
                    else if (CW'(i) == ins_pos) slot_op[i] = LOAD_NEW;
                    else                        slot_op[i] = TAKE_LOWER;
                end
            end
        end else if (pop_fire) begin
            count_d = count_q - CW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                slot_op[i] = TAKE_UPPER;
            end
        end
    end

    assign pop_data_o = valid[0] ? slot_data[0] : '0;
`else
    always_comb begin
        count_d       = count_q;
        evict_valid_d = 1'b0;
        evict_data_d  = evict_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            slot_op[i] = HOLD;
        end
        if (push_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_op[i] = (i == 0) ? LOAD_NEW : TAKE_LOWER;
            end
        end
        if (push_fire && !pop_fire) begin
            if (full) begin
                evict_valid_d = 1'b1;
                evict_data_d  = slot_data[DEPTH-1];
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_fire && !push_fire) begin
            // Dropping the oldest only shrinks the valid prefix.
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        pop_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_q) pop_data_o = slot_data[i];
        end
    end
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [WIDTH-1:0] lower;
        logic [WIDTH-1:0] upper;
        if (i == 0) begin : g_lo_edge
            assign lower = '0;
        end else begin : g_lo
            assign lower = slot_data[i-1];
        end
        if (i == DEPTH - 1) begin : g_up_edge
            assign upper = '0;
        end else begin : g_up
            assign upper = slot_data[i+1];
        end
        shift_pq_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk        (system1000),
            .rst_n      (system1000_rstn),
            .op         (slot_op[i]),
            .lower_data (lower),
            .upper_data (upper),
            .push_data  (push_data_i),
            .data       (slot_data[i])
        );
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            count_q       <= '0;
            ready_q       <= 1'b0;
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
        end else begin
            count_q       <= count_d;
            ready_q       <= 1'b1;
            evict_valid_q <= evict_valid_d;
            evict_data_q  <= evict_data_d;
        end
    end

    always_comb begin
        vec_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vec_o[i*WIDTH +: WIDTH] = valid[i] ? slot_data[i] : '0;
        end
    end

    assign push_ready_o  = ready_q;
    assign pop_valid_o   = (count_q != '0);
    assign evict_valid_o = evict_valid_q;
    assign evict_data_o  = evict_data_q;
    assign count_o       = count_q;

endmodule
